// File: rtl/uart_rx_fifo_if.sv
// Receive-side bundle between the UART receiver/FIFO and the bridge that
// drains it: serial line in, FIFO head, occupancy and sticky error flags out.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                          rx;
    logic                          pop;
    logic                          clear_err;
    logic [7:0]                    rx_data;
    logic                          ready;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          overrun;
    logic                          frame_err;

    modport slave (
        input  rx, pop, clear_err,
        output rx_data, ready, count, overrun, frame_err
    );

    modport master (
        output rx, pop, clear_err,
        input  rx_data, ready, count, overrun, frame_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first) feeding a first-word-fall-through FIFO, with
// sticky overrun / framing-error flags for the bridge status word.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic           clock_50M,
    input  logic           n_rst,
    uart_rx_fifo_if.slave  bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              rx_m;
    logic              rx_s;
    logic [CNT_W-1:0]  clk_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt_q;
    logic              overrun_q;
    logic              frame_err_q;

    logic              tick;
    logic              full;
    logic              pop_ok;
    logic              push;
    logic              drop;
    logic              bad_stop;

    // Sync flops reset high so a line already low at reset release is not a start bit
    always_ff @(posedge clock_50M or negedge n_rst) begin
        if (!n_rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    assign tick   = (state == S_START) ? (clk_cnt == HALF_END) : (clk_cnt == BIT_END);
    assign full   = (cnt_q == FULL_CNT);
    assign pop_ok = bus.pop && (cnt_q != '0);

    always_ff @(posedge clock_50M or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (!rx_s) next_state = S_START;
            S_START: if (tick) next_state = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (tick && bit_idx == 3'd7) next_state = S_STOP;
            S_STOP:  if (tick) next_state = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        push     = 1'b0;
        drop     = 1'b0;
        bad_stop = 1'b0;
        if (state == S_STOP && tick) begin
            if (rx_s) begin
                if (!full || bus.pop) push = 1'b1;
                else                  drop = 1'b1;
            end else begin
                bad_stop = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_50M or negedge n_rst) begin
        if (!n_rst) begin
            clk_cnt <= '0;
            bit_idx <= '0;
        end else begin
            clk_cnt <= (state == S_IDLE || tick) ? '0 : clk_cnt + 1'b1;
            if (state == S_START)
                bit_idx <= '0;
            else if (state == S_DATA && tick)
                bit_idx <= bit_idx + 1'b1;
        end
    end

    // Datapath storage carries no reset; the empty-gated read mux hides stale contents
    always_ff @(posedge clock_50M) begin
        if (state == S_DATA && tick)
            shreg <= {rx_s, shreg[7:1]};
        if (push)
            mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clock_50M or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            // A new event in the same cycle as clear_err keeps the flag set
            overrun_q   <= drop     | (overrun_q   & ~bus.clear_err);
            frame_err_q <= bad_stop | (frame_err_q & ~bus.clear_err);
        end
    end

    assign bus.ready     = (cnt_q != '0);
    assign bus.rx_data   = (cnt_q != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.count     = cnt_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks/bit with an 8-entry FIFO.
module tb_uart_rx_fifo;
    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic n_rst;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock_50M (clk),
        .n_rst     (n_rst),
        .bus       (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All drive changes happen on the falling edge, one bit = CPB cycles
    task automatic drive_bit(input logic v);
        bus.rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    // pop_at_stop raises pop for the single cycle the receiver samples the stop bit:
    // start bit driven at negedge N0 lands as a push on posedge 155 after N0
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic pop_at_stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pop_at_stop) begin
            bus.rx = stop_v;
            repeat (10) @(negedge clk);
            bus.pop = 1'b1;
            @(negedge clk);
            bus.pop = 1'b0;
            repeat (CPB - 11) @(negedge clk);
        end else begin
            drive_bit(stop_v);
        end
    endtask

    task automatic pop_one();
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
    endtask

    task automatic clear_flags();
        bus.clear_err = 1'b1;
        @(negedge clk);
        bus.clear_err = 1'b0;
    endtask

    initial begin
        n_rst         = 1'b0;
        bus.rx        = 1'b1;
        bus.pop       = 1'b0;
        bus.clear_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_data",  32'(bus.rx_data), 32'h00);
        chk("rst_ovr",   32'(bus.overrun), 32'd0);
        chk("rst_ferr",  32'(bus.frame_err), 32'd0);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);

        // single frame
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("a5_ready", 32'(bus.ready), 32'd1);
        chk("a5_data",  32'(bus.rx_data), 32'hA5);
        chk("a5_count", 32'(bus.count), 32'd1);
        pop_one();
        chk("a5_pop_ready", 32'(bus.ready), 32'd0);
        chk("a5_pop_count", 32'(bus.count), 32'd0);
        chk("a5_ovr",  32'(bus.overrun), 32'd0);
        chk("a5_ferr", 32'(bus.frame_err), 32'd0);

        // 5-cycle glitch is rejected at the start-bit midpoint
        bus.rx = 1'b0;
        repeat (5) @(negedge clk);
        bus.rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_count", 32'(bus.count), 32'd0);
        chk("glitch_ovr",   32'(bus.overrun), 32'd0);
        chk("glitch_ferr",  32'(bus.frame_err), 32'd0);

        // nine back-to-back frames, the ninth overruns
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0);
        chk("fill_count", 32'(bus.count), 32'd8);
        chk("fill_ovr",   32'(bus.overrun), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("fill_order", 32'(bus.rx_data), 32'(i));
            pop_one();
        end
        chk("drain_ready", 32'(bus.ready), 32'd0);
        clear_flags();
        chk("ovr_cleared", 32'(bus.overrun), 32'd0);

        // framing error followed by a long break, then a good frame
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(8'h3C >> i);
        bus.rx = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        chk("brk_ferr",  32'(bus.frame_err), 32'd1);
        chk("brk_count", 32'(bus.count), 32'd0);
        bus.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b0);
        chk("brk_ferr2",  32'(bus.frame_err), 32'd1);
        chk("brk_count2", 32'(bus.count), 32'd1);
        chk("brk_data",   32'(bus.rx_data), 32'h5A);
        pop_one();
        clear_flags();
        chk("ferr_cleared", 32'(bus.frame_err), 32'd0);

        // full FIFO, pop coincides with the stop sample: push succeeds
        for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0);
        chk("full_count", 32'(bus.count), 32'd8);
        send_frame(8'h77, 1'b1, 1'b1);
        chk("pp_ovr",   32'(bus.overrun), 32'd0);
        chk("pp_count", 32'(bus.count), 32'd8);
        for (int i = 1; i < 8; i++) begin
            chk("pp_order", 32'(bus.rx_data), 32'(8'h10 + i));
            pop_one();
        end
        chk("pp_last", 32'(bus.rx_data), 32'h77);
        pop_one();
        chk("pp_empty", 32'(bus.count), 32'd0);

        // reset in the middle of data bit 4 with three bytes queued
        send_frame(8'h21, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h23, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        bus.rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(bus.ready), 32'd0);
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_data",  32'(bus.rx_data), 32'h00);
        chk("mid_rst_ovr",   32'(bus.overrun), 32'd0);
        chk("mid_rst_ferr",  32'(bus.frame_err), 32'd0);
        repeat (6 * CPB) @(negedge clk);
        send_frame(8'h12, 1'b1, 1'b0);
        chk("post_rst_count", 32'(bus.count), 32'd1);
        chk("post_rst_data",  32'(bus.rx_data), 32'h12);
        chk("post_rst_ferr",  32'(bus.frame_err), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial UART receiver (8N1, LSB first) with an integrated first-word-fall-through receive FIFO. It is the receive counterpart to `uart_tx` and runs in the `clock_50M` domain. It replaces the single-byte `uart_rx` + `ready` pulse path, so back-to-back bytes arriving while the CPU/bridge is busy are buffered instead of overwritten. Error conditions are latched as sticky flags so the bridge can publish them in the UART status word.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); must be ≥ 4
- FIFO_DEPTH, 8, receive FIFO entries; power of two, ≥ 2

Ports:
- clock_50M  input  1  system clock; all logic on rising edge
- n_rst  input  1  asynchronous active-low reset
- rx  input  1  serial line, idle high, asynchronous to clock_50M
- pop  input  1  consume head byte this cycle; ignored when FIFO empty
- clear_err  input  1  clears `overrun` and `frame_err`
- rx_data  output  8  FIFO head byte; valid when `ready`=1
- ready  output  1  FIFO non-empty
- count  output  $clog2(FIFO_DEPTH)+1  bytes currently stored
- overrun  output  1  sticky: a good byte was dropped because the FIFO was full
- frame_err  output  1  sticky: a stop bit was sampled low

## Operation
- Input sync: two flops on `rx`, both reset to 1. The FSM sees only the second flop (`rx_s`).
- FSM states and behaviour:
  - IDLE: `rx_s`=0 → START, bit counter cleared.
  - START: count to CLKS_PER_BIT/2−1 (integer division), then sample `rx_s`. If 0 → DATA, counter=0, bit index=0. If 1 → IDLE (glitch rejected, nothing recorded).
  - DATA: count to CLKS_PER_BIT−1, then sample. Shift right with the sample entering bit 7. After the 8th sample → STOP.
  - STOP: count to CLKS_PER_BIT−1, then sample.
    - 1 and FIFO not full (or full with `pop` in the same cycle) → push shift register, then IDLE.
    - 1 and FIFO full without `pop` → set `overrun`, discard the byte, then IDLE.
    - 0 → set `frame_err`, discard the byte, then BREAK.
  - BREAK: wait for `rx_s`=1 → IDLE. This prevents a held-low line from being read as repeated start bits.
- FIFO: storage array with wrap-around read/write pointers of $clog2(FIFO_DEPTH) bits and a separate `count`.
  - `rx_data` = mem[rd_ptr], combinational from registered state.
  - Push and pop in the same cycle: both take effect and `count` is unchanged. When full this still counts as a successful push, not an overrun.
  - `pop` while empty: no effect. `count` never underflows.
- Error flags: set by events, cleared only by `clear_err` or reset. If set and clear occur in the same cycle, set wins.
- Reset mid-frame: FSM → IDLE, FIFO emptied, the partial byte is lost. After reset the line must be seen going high→low again before a new frame starts (sync flops reset to 1).

## Timing
- Reset values:
  - `rx_data`=8'h00 (mem contents are don't-care, but read mux and pointers reset to 0 so the output is 0)
  - `ready`=0, `count`=0, `overrun`=0, `frame_err`=0
  - FSM in IDLE
- Detection latency: a falling edge on `rx` is seen by IDLE 2 cycles later.
- Sample points, measured from the first cycle the FSM is in START:
  - start bit at CLKS_PER_BIT/2 cycles
  - data bit n at CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT
  - stop bit at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT
- Push is registered on the stop-sample cycle. `ready`, `count`, and `rx_data` update on the next edge.
- `pop` takes effect on the edge where it is sampled high. The next head byte is visible the following cycle.
- Flags assert 1 cycle after the stop-sample cycle.
- Back-to-back frames: IDLE is re-entered about half a bit before the line's stop bit ends, so a start bit following immediately is caught.
- Throughput: one byte per 10 bit times, sustained indefinitely with concurrent pops.

## Test plan
All scenarios use CLKS_PER_BIT=16, FIFO_DEPTH=8.
- Single frame 0xA5 at 16 cycles/bit → `ready`=1, `rx_data`=0xA5, `count`=1. After one `pop` cycle → `ready`=0, `count`=0, no flags set.
- 5-cycle low glitch on `rx`, then idle → no push, `count`=0, flags 0, FSM back in IDLE.
- 9 back-to-back frames 0x00..0x08 with no pops → `count`=8, `overrun`=1, and 8 pops read 0x00..0x07 in order. Then `clear_err` → `overrun`=0.
- Frame 0x3C with stop bit 0 and line held low for 30 bit times, then frame 0x5A → `frame_err`=1, only 0x5A stored, `count`=1.
- FIFO full with `pop` asserted exactly on the stop-sample cycle of frame 0x77 → `overrun`=0, `count` stays 8, 0x77 is the last byte read.
- `n_rst` pulsed low during DATA bit 4 of frame 0xFF with 3 bytes queued → all outputs at reset values. The next full frame 0x12 is received correctly.
